// File: rtl/mem_access_unit_pkg.sv
// Shared op/state encodings and request decode helpers for mem_access_unit.
// Only pure combinational helpers live here, so they can be used in any process.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_load(input op_e op);
    return (op <= OP_LBU);
  endfunction

  // Misalignment for the access size, or any address outside the 64 KiB window.
  function automatic logic addr_err(input op_e op, input logic [31:0] addr);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = addr[0];
      default:              mis = 1'b0;
    endcase
    return mis || (addr[31:16] != 16'h0000);
  endfunction

  function automatic logic [3:0] store_we(input op_e op, input logic [1:0] addr_lo);
    case (op)
      OP_SW:   return 4'b1111;
      OP_SH:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return 4'b0001 << addr_lo;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory signals of mem_access_unit.
// slave is the unit's view; master is the pipeline plus memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata, rsp_ready,
    output req_ready, dm_addr, dm_wdata, dm_we, dm_pc, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata, rsp_ready,
    input  req_ready, dm_addr, dm_wdata, dm_we, dm_pc, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load data extraction: selects byte/half from the read word and sign/zero-extends.
// Purely combinational; stores yield 0.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    case (i_op)
      OP_LW:   o_result = i_word;
      OP_LH:   o_result = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_result = {16'h0000, w_half};
      OP_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_result = {24'h000000, w_byte};
      default: o_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: accept -> ISSUE -> RESP, response 2 cycles after accept.
// req_ready only in IDLE; the response is held in RESP until rsp_ready.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  state_e      r_state;
  state_e      w_next;
  op_e         r_op;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] w_ext;
  logic        w_req_err;

  assign w_req_err = addr_err(op_e'(bus.req_op), bus.req_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // dm_we is decoded from state, so an async reset clears it without a clock edge.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.dm_we     = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = w_req_err ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.dm_we = store_we(r_op, r_addr[1:0]);
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= OP_LW;
      r_addr  <= 16'h0000;
      r_wdata <= 32'h0000_0000;
      r_pc    <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (r_state == ST_IDLE && bus.req_valid) begin
      r_op    <= op_e'(bus.req_op);
      r_addr  <= bus.req_addr[15:0];
      r_wdata <= bus.req_wdata;
      r_pc    <= bus.req_pc;
      r_rdata <= 32'h0000_0000;
      r_err   <= w_req_err;
    end else if (r_state == ST_ISSUE && is_load(r_op)) begin
      r_rdata <= w_ext;
    end
  end

  load_extend u_load_extend (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (bus.dm_rdata),
    .o_result  (w_ext)
  );

  assign bus.dm_addr   = r_addr[15:2];
  assign bus.dm_wdata  = r_wdata;
  assign bus.dm_pc     = r_pc;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a response scoreboard.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk;
  logic reset;
  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:16383];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        if (we == 4'b1111)                       r[8*k +: 8] = wd[8*k +: 8];
        else if (we == 4'b0011 || we == 4'b1100) r[8*k +: 8] = wd[8*(k%2) +: 8];
        else                                     r[8*k +: 8] = wd[7:0];
      end
    end
    return r;
  endfunction

  assign bus.dm_rdata = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (bus.dm_we != 4'b0000) mem[bus.dm_addr] <= merge(mem[bus.dm_addr], bus.dm_we, bus.dm_wdata);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every completed response handshake.
  always @(negedge clk) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the edge that completes the response.
  task automatic do_req(input string name, input op_e op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc, input logic [3:0] exp_we,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    sb.push_back('{exp_rdata, exp_err});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!exp_err) begin
      check({name, "_dm_we"},    32'(bus.dm_we), 32'(exp_we));
      check({name, "_dm_addr"},  32'(bus.dm_addr), {18'h0, addr[15:2]});
      check({name, "_dm_wdata"}, bus.dm_wdata, wdata);
      check({name, "_dm_pc"},    bus.dm_pc, pc);
      check({name, "_early_vld"}, 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end else begin
      check({name, "_err_we"}, 32'(bus.dm_we), 32'd0);
    end
    check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({name, "_resp_we"},   32'(bus.dm_we), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_pc    = 32'h0;
    bus.rsp_ready = 1'b1;
    #2;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_dm_we",     32'(bus.dm_we), 32'd0);
    check("rst_dm_addr",   32'(bus.dm_addr), 32'd0);
    check("rst_dm_wdata",  bus.dm_wdata, 32'd0);
    check("rst_dm_pc",     bus.dm_pc, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_req("sw",     OP_SW,  32'h10, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 1'b0);
    do_req("sb",     OP_SB,  32'h13, 32'h000000AB, 32'h104, 4'b1000, 32'h0, 1'b0);
    do_req("lw",     OP_LW,  32'h10, 32'h0,        32'h108, 4'b0000, 32'hABADBEEF, 1'b0);
    do_req("sw2",    OP_SW,  32'h20, 32'h80F07F01, 32'h10C, 4'b1111, 32'h0, 1'b0);
    do_req("lb0",    OP_LB,  32'h20, 32'h0, 32'h110, 4'b0000, 32'h00000001, 1'b0);
    do_req("lb1",    OP_LB,  32'h21, 32'h0, 32'h114, 4'b0000, 32'h0000007F, 1'b0);
    do_req("lb2",    OP_LB,  32'h22, 32'h0, 32'h118, 4'b0000, 32'hFFFFFFF0, 1'b0);
    do_req("lb3",    OP_LB,  32'h23, 32'h0, 32'h11C, 4'b0000, 32'hFFFFFF80, 1'b0);
    do_req("lbu3",   OP_LBU, 32'h23, 32'h0, 32'h120, 4'b0000, 32'h00000080, 1'b0);
    do_req("lhu2",   OP_LHU, 32'h22, 32'h0, 32'h124, 4'b0000, 32'h000080F0, 1'b0);
    do_req("lh2",    OP_LH,  32'h22, 32'h0, 32'h128, 4'b0000, 32'hFFFF80F0, 1'b0);
    do_req("lh0",    OP_LH,  32'h20, 32'h0, 32'h12C, 4'b0000, 32'h00007F01, 1'b0);
    do_req("sh_lo",  OP_SH,  32'h24, 32'h00001234, 32'h130, 4'b0011, 32'h0, 1'b0);
    do_req("sh_hi",  OP_SH,  32'h26, 32'h00005678, 32'h134, 4'b1100, 32'h0, 1'b0);
    do_req("lw_sh",  OP_LW,  32'h24, 32'h0, 32'h138, 4'b0000, 32'h56781234, 1'b0);
    do_req("sh_mis", OP_SH,  32'h11, 32'h0000FFFF, 32'h13C, 4'b0000, 32'h0, 1'b1);
    do_req("lw_oor", OP_LW,  32'h00010000, 32'h0, 32'h140, 4'b0000, 32'h0, 1'b1);
    do_req("sw_mis", OP_SW,  32'h12, 32'h11111111, 32'h144, 4'b0000, 32'h0, 1'b1);
    do_req("lbu_oor", OP_LBU, 32'h80000013, 32'h0, 32'h148, 4'b0000, 32'h0, 1'b1);

    // Backpressure: response held for 5 cycles while a competing request is offered.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h10;
    bus.req_pc    = 32'h200;
    sb.push_back('{32'hABADBEEF, 1'b0});
    @(posedge clk); #1;
    bus.req_op    = OP_SW;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h55555555;
    check("bp_issue_we", 32'(bus.dm_we), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'hABADBEEF);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_dm_we",     32'(bus.dm_we), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    check("bp_idle_vld",   32'(bus.rsp_valid), 32'd0);

    // Reset asserted during the ISSUE cycle of a store.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SW;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h22222222;
    bus.req_pc    = 32'h300;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_mid_we_before", 32'(bus.dm_we), 32'd15);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_we_async", 32'(bus.dm_we), 32'd0);
    check("rst_mid_vld",      32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rel_vld",   32'(bus.rsp_valid), 32'd0);
    do_req("lw_after", OP_LW, 32'h30, 32'h0, 32'h304, 4'b0000, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and one asynchronous active-low reset; the ports are clk (clock) and reset (asserted low).
REQ-002 SHALL have port list (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active low
- req_valid  in  1  pipeline memory request present
- req_ready  out  1  unit accepts a request this cycle
- req_op  in  3  operation code: LW, LH, LHU, LB, LBU, SW, SH, SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_pc  in  32  PC of the requesting instruction, passed through for the store trace
- dm_addr  out  14  word address to data memory, equal to req_addr[15:2]
- dm_wdata  out  32  store data to memory
- dm_we  out  4  byte-lane write enables to memory
- dm_pc  out  32  PC to memory for the store trace
- dm_rdata  in  32  combinational read word from memory
- rsp_valid  out  1  response available
- rsp_ready  in  1  pipeline takes the response
- rsp_rdata  out  32  load result, sign- or zero-extended
- rsp_err  out  1  request was misaligned or out of range; no memory access was made

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-004 SHALL accept a request on a clk edge where req_valid&&req_ready, registering op, addr, wdata and pc.
REQ-005 SHALL set rsp_err on any of: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; addr[31:16]!=0.
REQ-006 SHALL go IDLE -> RESP directly on an error request; dm_we stays 4'b0000 throughout.
REQ-007 SHALL drive dm_addr, dm_wdata and dm_pc from the registered request during ISSUE.
REQ-008 SHALL assert dm_we only in ISSUE and for exactly one cycle per request.
REQ-009 SHALL drive dm_we = 4'b0000 in every state except ISSUE.
REQ-010 SHALL use dm_we = 4'b1111 for SW.
REQ-011 SHALL use dm_we = 4'b0011 for SH with addr[1]=0, and 4'b1100 for SH with addr[1]=1.
REQ-012 SHALL use dm_we = 4'b0001 shifted left by addr[1:0] for SB.
REQ-013 SHALL use dm_we = 4'b0000 for all loads.
REQ-014 SHALL pass dm_wdata = req_wdata unshifted; the memory takes the low byte or low half for each enabled lane.
REQ-015 SHALL capture dm_rdata at the clock edge that ends ISSUE, for loads only.
REQ-016 SHALL form rsp_rdata as follows:
- LW: the full word.
- LH/LHU: half addr[1], i.e. bits [16*addr[1]+15 : 16*addr[1]], sign-extended for LH, zero-extended for LHU.
- LB/LBU: byte addr[1:0], sign-extended for LB, zero-extended for LBU.
- Stores and error responses: 0.
REQ-017 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-018 SHALL give a fixed latency: accept at edge N, ISSUE in cycle N+1, rsp_valid from edge N+2; zero-wait throughput is one request per 3 cycles.
REQ-019 SHALL ignore req_valid outside IDLE; no request is lost because req_ready=0 in those states.

Reset
REQ-020 SHALL, while reset=0, force the FSM to IDLE and these outputs to their reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_pc=0.
REQ-021 SHALL, when reset asserts mid-operation (ISSUE or RESP), drop dm_we to 0 without waiting for a clock edge and discard the pending response.

Structure
REQ-022 SHALL place the op encodings in a shared package: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
REQ-023 SHALL place the FSM state encoding in the same shared package.
REQ-024 SHALL place load extraction in a combinational sub-module load_extend (op, addr[1:0], word -> result).

Verification
REQ-025 SHALL cover: SW addr=0x0000_0010, wdata=0xDEADBEEF -> one ISSUE cycle with dm_addr=0x004, dm_we=1111, dm_wdata=0xDEADBEEF; rsp_valid two cycles after accept; rsp_err=0.
REQ-026 SHALL cover: SB addr=0x13, wdata=0x000000AB -> dm_we=1000 for one cycle; LW addr=0x10 afterwards -> rsp_rdata=0xABADBEEF.
REQ-027 SHALL cover: with memory word 0x80F07F01, each of LB at offsets 0-3 -> 0x01, 0x7F, 0xFFFFFFF0, 0xFFFFFF80; LHU at offset 2 -> 0x000080F0; LH at offset 2 -> 0xFFFF80F0.
REQ-028 SHALL cover: SH addr=0x11 -> rsp_err=1, dm_we never nonzero; LW addr=0x0001_0000 -> rsp_err=1, rsp_rdata=0.
REQ-029 SHALL cover: rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 and a concurrent req_valid is ignored; rsp_ready=1 -> IDLE on the next edge.
REQ-030 SHALL cover: reset driven low during ISSUE of an SW -> dm_we=0 at once with no clock edge, and after release the FSM is in IDLE with rsp_valid=0.
